// File: rtl/fifo_rd_ctrl_if.sv
// Consumer-side handshake bundle for the FIFO read controller.
//   master : drives r_Valid / r_Data, samples r_Ready (the controller)
//   slave  : samples r_Valid / r_Data, drives r_Ready (the consumer)
interface fifo_rd_ctrl_if #(
  parameter int data_Size = 8
);
  logic                 r_Valid;
  logic                 r_Ready;
  logic [data_Size-1:0] r_Data;

  modport master (
    output r_Valid,
    output r_Data,
    input  r_Ready
  );

  modport slave (
    input  r_Valid,
    input  r_Data,
    output r_Ready
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: owns the read pointer, the empty flag
// and a first-word-fall-through output register.
//   r_Clk, r_Rst : read clock, synchronous active-high reset
//   w_Ptr_Sync   : write pointer (Gray), already synchronised to r_Clk
//   mem_Data     : combinational read data of fifomem at r_Addr
//   r_Addr       : fifomem read address (low bits of the binary read pointer)
//   r_Ptr_Gray   : registered Gray read pointer for the write-side synchroniser
//   fifo_Empty   : no unread word left in memory (output register may still hold one)
//   r_Count      : words still in memory, registered
//   rd_if        : r_Valid / r_Ready / r_Data consumer handshake
module fifo_rd_ctrl #(
  parameter int data_Size    = 8,
  parameter int address_Size = 5
) (
  input  logic                    r_Clk,
  input  logic                    r_Rst,
  input  logic [address_Size:0]   w_Ptr_Sync,
  input  logic [data_Size-1:0]    mem_Data,
  output logic [address_Size-1:0] r_Addr,
  output logic [address_Size:0]   r_Ptr_Gray,
  output logic                    fifo_Empty,
  output logic [address_Size:0]   r_Count,
  fifo_rd_ctrl_if.master          rd_if
);
  localparam int A = address_Size;

  logic [A:0]           r_bin_q;
  logic [A:0]           r_bin_d;
  logic [A:0]           r_gray_q;
  logic [A:0]           r_gray_d;
  logic [A:0]           w_bin;
  logic                 empty_q;
  logic                 valid_q;
  logic [data_Size-1:0] data_q;
  logic [A:0]           count_q;
  logic                 pop;

  function automatic logic [A:0] gray2bin(input logic [A:0] g);
    logic [A:0] b;
    b[A] = g[A];
    for (int i = A - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Fetch a new word whenever memory has one and the output slot is free
  // or being drained this cycle; this gives one word per cycle sustained.
  always_comb begin
    pop      = !empty_q && (!valid_q || rd_if.r_Ready);
    r_bin_d  = r_bin_q + {{A{1'b0}}, pop};
    r_gray_d = r_bin_d ^ (r_bin_d >> 1);
    w_bin    = gray2bin(w_Ptr_Sync);
  end

  always_ff @(posedge r_Clk) begin
    if (r_Rst) begin
      r_bin_q  <= '0;
      r_gray_q <= '0;
      empty_q  <= 1'b1;
      valid_q  <= 1'b0;
      data_q   <= '0;
      count_q  <= '0;
    end else begin
      r_bin_q  <= r_bin_d;
      r_gray_q <= r_gray_d;
      // Compare against the post-pop pointer so empty is exact the cycle
      // the last word is taken out of memory.
      empty_q  <= (r_gray_d == w_Ptr_Sync);
      count_q  <= w_bin - r_bin_d;
      if (pop) begin
        data_q  <= mem_Data;
        valid_q <= 1'b1;
      end else if (rd_if.r_Ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign r_Addr        = r_bin_q[A-1:0];
  assign r_Ptr_Gray    = r_gray_q;
  assign fifo_Empty    = empty_q;
  assign r_Count       = count_q;
  assign rd_if.r_Valid = valid_q;
  assign rd_if.r_Data  = data_q;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: vector table for the short handshake
// sequences, hand-written loops for wrap, full and idle cases.
module tb_fifo_rd_ctrl;
  localparam int D = 8;
  localparam int A = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [A:0]   w_ptr;
  logic [D-1:0] mem_data;
  logic [A-1:0] r_addr;
  logic [A:0]   r_gray;
  logic         empty;
  logic [A:0]   r_count;
  logic [D-1:0] mem [0:31];

  fifo_rd_ctrl_if #(.data_Size(D)) rd_if ();

  fifo_rd_ctrl #(.data_Size(D), .address_Size(A)) dut (
    .r_Clk      (clk),
    .r_Rst      (rst),
    .w_Ptr_Sync (w_ptr),
    .mem_Data   (mem_data),
    .r_Addr     (r_addr),
    .r_Ptr_Gray (r_gray),
    .fifo_Empty (empty),
    .r_Count    (r_count),
    .rd_if      (rd_if)
  );

  always #5 clk = ~clk;
  assign mem_data = mem[r_addr];

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    int         wb;
    logic       rdy;
    logic       e_val;
    logic [7:0] e_dat;
    logic       e_emp;
    logic [4:0] e_adr;
    logic [5:0] e_cnt;
    logic [5:0] e_gry;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic rs, int wb, logic rdy, logic v, logic [7:0] d,
                              logic e, logic [4:0] ad, logic [5:0] c, logic [5:0] g);
    vec_t t;
    t.rst = rs; t.wb = wb; t.rdy = rdy; t.e_val = v; t.e_dat = d;
    t.e_emp = e; t.e_adr = ad; t.e_cnt = c; t.e_gry = g;
    return t;
  endfunction

  function automatic logic [A:0] gray(input int b);
    logic [A:0] x;
    x = b[A:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int got;
    logic [4:0] pa;
    logic [5:0] pg;
    logic wrapped;

    for (int i = 0; i < 32; i++) mem[i] = 8'(8'h40 + i);
    mem[0] = 8'hA1;
    mem[1] = 8'hB2;
    mem[2] = 8'hC3;

    // idle after reset, consumer ready toggling
    rst = 1'b1; w_ptr = '0; rd_if.r_Ready = 1'b0;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd_if.r_Ready = 1'(i % 2);
      step();
      chk($sformatf("idle%0d empty", i), empty, 1);
      chk($sformatf("idle%0d valid", i), rd_if.r_Valid, 0);
      chk($sformatf("idle%0d addr", i), r_addr, 0);
      chk($sformatf("idle%0d count", i), r_count, 0);
    end

    // three-word drain with consumer always ready
    tv.push_back(mk(1, 0, 0, 0, 8'h00, 1, 0, 0, 0));
    tv.push_back(mk(0, 3, 1, 0, 8'h00, 0, 0, 3, 0));
    tv.push_back(mk(0, 3, 1, 1, 8'hA1, 0, 1, 2, 1));
    tv.push_back(mk(0, 3, 1, 1, 8'hB2, 0, 2, 1, 3));
    tv.push_back(mk(0, 3, 1, 1, 8'hC3, 1, 3, 0, 2));
    tv.push_back(mk(0, 3, 1, 0, 8'hC3, 1, 3, 0, 2));
    // stalled consumer, then a one-cycle ready pulse
    tv.push_back(mk(1, 0, 0, 0, 8'h00, 1, 0, 0, 0));
    tv.push_back(mk(0, 3, 0, 0, 8'h00, 0, 0, 3, 0));
    tv.push_back(mk(0, 3, 0, 1, 8'hA1, 0, 1, 2, 1));
    tv.push_back(mk(0, 3, 0, 1, 8'hA1, 0, 1, 2, 1));
    tv.push_back(mk(0, 3, 0, 1, 8'hA1, 0, 1, 2, 1));
    tv.push_back(mk(0, 3, 1, 1, 8'hB2, 0, 2, 1, 3));
    tv.push_back(mk(0, 3, 0, 1, 8'hB2, 0, 2, 1, 3));
    // reset mid-drain with five words left in memory
    tv.push_back(mk(1, 0, 0, 0, 8'h00, 1, 0, 0, 0));
    tv.push_back(mk(0, 7, 0, 0, 8'h00, 0, 0, 7, 0));
    tv.push_back(mk(0, 7, 0, 1, 8'hA1, 0, 1, 6, 1));
    tv.push_back(mk(0, 7, 1, 1, 8'hB2, 0, 2, 5, 3));
    tv.push_back(mk(1, 7, 0, 0, 8'h00, 1, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 0));

    for (int i = 0; i < tv.size(); i++) begin
      rst = tv[i].rst;
      w_ptr = gray(tv[i].wb);
      rd_if.r_Ready = tv[i].rdy;
      step();
      chk($sformatf("v%0d valid", i), rd_if.r_Valid, tv[i].e_val);
      chk($sformatf("v%0d data", i), rd_if.r_Data, tv[i].e_dat);
      chk($sformatf("v%0d empty", i), empty, tv[i].e_emp);
      chk($sformatf("v%0d addr", i), r_addr, tv[i].e_adr);
      chk($sformatf("v%0d count", i), r_count, tv[i].e_cnt);
      chk($sformatf("v%0d gray", i), r_gray, tv[i].e_gry);
    end

    // wrap: 33 words, then 7 more, consumer always ready
    rst = 1'b1; w_ptr = '0; rd_if.r_Ready = 1'b1;
    step();
    rst = 1'b0; w_ptr = gray(33);
    got = 0; pa = '0; pg = '0; wrapped = 1'b0;
    for (int c = 0; c < 120 && got < 40; c++) begin
      step();
      if (rd_if.r_Valid) begin
        chk($sformatf("wrap data%0d", got), rd_if.r_Data, mem[got % 32]);
        got++;
      end
      if (pa == 5'd31 && r_addr == 5'd0) wrapped = 1'b1;
      pa = r_addr;
      chk($sformatf("wrap gray1bit c%0d", c), ($countones(r_gray ^ pg) <= 1), 1);
      pg = r_gray;
      if (got == 33) w_ptr = gray(40);
    end
    chk("wrap words", got, 40);
    chk("wrap addr31to0", wrapped, 1);
    step(); step();
    chk("wrap gray", r_gray, 6'b111100);
    chk("wrap msb", r_gray[5], 1);
    chk("wrap empty", empty, 1);
    chk("wrap valid", rd_if.r_Valid, 0);
    chk("wrap count", r_count, 0);
    chk("wrap addr", r_addr, 8);

    // full memory, consumer stalled: exactly one pop
    rst = 1'b1; w_ptr = '0; rd_if.r_Ready = 1'b0;
    step();
    rst = 1'b0; w_ptr = gray(32);
    step();
    chk("full count0", r_count, 32);
    chk("full valid0", rd_if.r_Valid, 0);
    chk("full empty0", empty, 0);
    step();
    chk("full count1", r_count, 31);
    chk("full valid1", rd_if.r_Valid, 1);
    chk("full data1", rd_if.r_Data, 8'hA1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("full hold%0d count", i), r_count, 31);
      chk($sformatf("full hold%0d addr", i), r_addr, 1);
      chk($sformatf("full hold%0d data", i), rd_if.r_Data, 8'hA1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
